// File: rtl/addr_reg_pair.sv
// Two-half address register (M/J/PC) with a relay-settle write sequencer.
// Writes commit SETTLE+1 edges after acceptance; bus drive is blocked while busy.
module addr_reg_pair #(
   parameter int unsigned       W         = 8,
   parameter int unsigned       SETTLE    = 3,
   parameter logic [2*W-1:0]    RESET_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_lo,
   input  logic            ld_hi,
   input  logic            ld_full,
   input  logic            inc,
   input  logic            sel,
   input  logic [W-1:0]    data_in,
   input  logic [2*W-1:0]  addr_in,
   output logic [2*W-1:0]  addr_out,
   output logic            addr_oe,
   output logic [2*W-1:0]  content,
   output logic            busy,
   output logic            done,
   output logic            carry,
   output logic            cmd_err,
   output logic            led_ld,
   output logic            led_sel
);

   localparam int unsigned AW = 2 * W;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COMMIT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   cap_q, cap_d;
   logic            cpend_q, cpend_d;
   logic [AW-1:0]   content_q, content_d;
   logic [AW-1:0]   addr_out_q, addr_out_d;
   logic            oe_q, oe_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            carry_q, carry_d;
   logic            err_q, err_d;
   logic            cmd;

   assign cmd = ld_full | ld_hi | ld_lo | inc;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cap_q      <= RESET_VAL;
         cpend_q    <= 1'b0;
         content_q  <= RESET_VAL;
         addr_out_q <= RESET_VAL;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cap_q      <= cap_d;
         cpend_q    <= cpend_d;
         content_q  <= content_d;
         addr_out_q <= addr_out_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         carry_q    <= carry_d;
         err_q      <= err_d;
      end
   end

   // Next-state, operand capture and registered-output decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      cpend_d   = cpend_q;
      content_d = content_q;

      case (state_q)
         S_IDLE: begin
            if (cmd) begin
               state_d = S_SETTLE;
               cnt_d   = CW'(SETTLE - 1);
               cpend_d = 1'b0;
               if (ld_full) begin
                  cap_d = addr_in;
               end else if (ld_hi || ld_lo) begin
                  // Unselected half keeps its value; content is frozen until commit.
                  cap_d = {(ld_hi ? data_in : content_q[AW-1:W]),
                           (ld_lo ? data_in : content_q[W-1:0])};
               end else begin
                  cap_d   = content_q + AW'(1);
                  cpend_d = &content_q;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_COMMIT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_COMMIT: begin
            content_d = cap_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_COMMIT);
      carry_d    = (state_d == S_COMMIT) & cpend_d;
      err_d      = cmd & (state_q != S_IDLE);
      oe_d       = sel & (state_q == S_IDLE) & ~cmd;
      addr_out_d = oe_d ? content_q : addr_out_q;
   end

   assign addr_out = addr_out_q;
   assign addr_oe  = oe_q;
   assign content  = content_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign carry    = carry_q;
   assign cmd_err  = err_q;
   assign led_ld   = busy_q;
   assign led_sel  = oe_q;

endmodule

// File: tb/tb_addr_reg_pair.sv
// Directed bench for addr_reg_pair (W=8, SETTLE=3, RESET_VAL=0).
module tb_addr_reg_pair;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_lo, ld_hi, ld_full, inc, sel;
   logic [7:0]  data_in;
   logic [15:0] addr_in;
   logic [15:0] addr_out;
   logic        addr_oe;
   logic [15:0] content;
   logic        busy, done, carry, cmd_err, led_ld, led_sel;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   addr_reg_pair #(.W(8), .SETTLE(3), .RESET_VAL(16'h0000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_lo    (ld_lo),
      .ld_hi    (ld_hi),
      .ld_full  (ld_full),
      .inc      (inc),
      .sel      (sel),
      .data_in  (data_in),
      .addr_in  (addr_in),
      .addr_out (addr_out),
      .addr_oe  (addr_oe),
      .content  (content),
      .busy     (busy),
      .done     (done),
      .carry    (carry),
      .cmd_err  (cmd_err),
      .led_ld   (led_ld),
      .led_sel  (led_sel)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the done pulse, check carry there, then the committed content.
   task automatic wait_commit(input string tag, input logic [15:0] exp_val, input logic exp_carry);
      int n = 0;
      while (!done && n < 20) begin
         chk({tag, "_oe_vs_busy"}, 32'(addr_oe & busy), 32'd0);
         step();
         n++;
      end
      if (!done) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_carry"}, 32'(carry), 32'(exp_carry));
         step();
         chk({tag, "_content"}, 32'(content), 32'(exp_val));
         chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ld_lo = 0; ld_hi = 0; ld_full = 0; inc = 0; sel = 0;
      data_in = '0; addr_in = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_content", 32'(content), 32'h0);
      chk("rst_oe", 32'(addr_oe), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_addr_out", 32'(addr_out), 32'h0);
      step(); step();
      rst_n = 1'b1;
      step();

      // High-half load: busy for 4 cycles, done in the 4th, content after edge 4
      ld_hi = 1; data_in = 8'hA5;
      step();
      ld_hi = 0;
      for (int i = 0; i < 4; i++) begin
         chk("hi_busy", 32'(busy), 32'd1);
         chk("hi_led_ld", 32'(led_ld), 32'd1);
         chk("hi_done", 32'(done), 32'(i == 3));
         chk("hi_content_hold", 32'(content), 32'h0);
         step();
      end
      chk("hi_content", 32'(content), 32'hA500);
      chk("hi_busy_off", 32'(busy), 32'd0);
      chk("hi_done_off", 32'(done), 32'd0);

      ld_lo = 1; data_in = 8'h3C;
      step();
      ld_lo = 0;
      wait_commit("lo", 16'hA53C, 1'b0);

      // Priority: ld_full beats half loads and inc
      ld_full = 1; ld_hi = 1; inc = 1; addr_in = 16'h5678; data_in = 8'h99;
      step();
      ld_full = 0; ld_hi = 0; inc = 0;
      wait_commit("prio", 16'h5678, 1'b0);

      ld_full = 1; addr_in = 16'hFFFF;
      step();
      ld_full = 0;
      wait_commit("ffff", 16'hFFFF, 1'b0);

      inc = 1;
      step();
      inc = 0;
      wait_commit("wrap", 16'h0000, 1'b1);
      chk("wrap_carry_off", 32'(carry), 32'd0);

      inc = 1;
      step();
      inc = 0;
      wait_commit("inc0", 16'h0001, 1'b0);

      // Command while busy is dropped with a one-cycle cmd_err
      ld_full = 1; addr_in = 16'h1234;
      step();
      ld_full = 0;
      chk("err_none_on_accept", 32'(cmd_err), 32'd0);
      ld_lo = 1; data_in = 8'hFF;
      step();
      ld_lo = 0;
      chk("err_pulse", 32'(cmd_err), 32'd1);
      step();
      chk("err_pulse_off", 32'(cmd_err), 32'd0);
      wait_commit("busyld", 16'h1234, 1'b0);

      // Bus drive lags sel by one cycle
      chk("sel_oe_idle", 32'(addr_oe), 32'd0);
      sel = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sel_oe", 32'(addr_oe), 32'd1);
         chk("sel_led", 32'(led_sel), 32'd1);
         chk("sel_addr_out", 32'(addr_out), 32'h1234);
      end
      sel = 0;
      step();
      chk("sel_oe_drop", 32'(addr_oe), 32'd0);
      chk("sel_addr_hold", 32'(addr_out), 32'h1234);

      // Write accepted while sel=1 takes the bus away
      sel = 1;
      step();
      chk("incsel_oe_on", 32'(addr_oe), 32'd1);
      inc = 1;
      step();
      inc = 0;
      chk("incsel_oe_off", 32'(addr_oe), 32'd0);
      chk("incsel_busy", 32'(busy), 32'd1);
      wait_commit("incsel", 16'h1235, 1'b0);
      chk("incsel_oe_commit", 32'(addr_oe), 32'd0);
      step();
      chk("incsel_oe_back", 32'(addr_oe), 32'd1);
      chk("incsel_addr_out", 32'(addr_out), 32'h1235);
      sel = 0;
      step();

      // Reset mid-settle discards the write
      ld_full = 1; addr_in = 16'hBEEF;
      step();
      ld_full = 0;
      step(); step();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_content", 32'(content), 32'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("midrst_no_done", 32'(done), 32'd0);
         chk("midrst_no_busy", 32'(busy), 32'd0);
         chk("midrst_hold", 32'(content), 32'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/addr_reg_pair.md
Name: addr_reg_pair

Overview:
- Parametrised successor to the single-half address-bus register (M1/M2 style).
- Holds a 2W-bit address as independent hi/lo halves.
  - Each half is loadable from the W-bit data bus.
  - The full word is loadable from the address bus, incrementable in place, and drivable onto the address bus.
- Adds a relay-settle sequencer: every write completes SETTLE cycles after acceptance, reported by busy/done. This models relay pull-in time.
- Sits in the register unit between the data bus, the address bus and the control sequencer. Serves as M, J or PC.

Parameters:
- W, 8, width of each half; address width is 2W.
- SETTLE, 3, cycles from command acceptance to register update (legal range 1..15).
- RESET_VAL, 0, reset value of the 2W-bit content.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ld_lo  in  1  load low half from data_in
- ld_hi  in  1  load high half from data_in
- ld_full  in  1  load full word from addr_in
- inc  in  1  increment content by 1
- sel  in  1  request to drive content onto address bus
- data_in  in  W  data bus value
- addr_in  in  2W  address bus value (read side)
- addr_out  out  2W  address bus drive value
- addr_oe  out  1  address bus drive enable
- content  out  2W  current register value
- busy  out  1  write in progress
- done  out  1  one-cycle pulse when a write commits
- carry  out  1  one-cycle pulse with done when inc wrapped
- cmd_err  out  1  one-cycle pulse when a write command was dropped
- led_ld  out  1  lamp: high from acceptance through commit of any load/inc
- led_sel  out  1  lamp: mirrors addr_oe

Behaviour:
- Reset (async, rst_n=0):
  - content=RESET_VAL; state=IDLE.
  - addr_oe, busy, done, carry, cmd_err, led_ld, led_sel all 0.
  - addr_out=RESET_VAL.
  - Any in-flight write is discarded.
- States: IDLE, SETTLE, COMMIT.
- IDLE, write command present (ld_full|ld_hi|ld_lo|inc):
  - Priority: ld_full > (ld_hi and/or ld_lo, both may apply together) > inc.
  - Operands are captured on the acceptance edge: data_in, addr_in, or content+1 mod 2^(2W).
  - carry_pending = (content == all ones) for inc.
  - Goes to SETTLE with counter=SETTLE-1; busy=1 and led_ld=1 from the next cycle.
- SETTLE:
  - Counter decrements each cycle.
  - At 0, goes to COMMIT.
  - SETTLE=1 means COMMIT follows acceptance directly.
- COMMIT (one cycle):
  - content takes the captured value at the end of this cycle.
  - Half loads change only the selected half(s).
  - done=1 and carry=carry_pending in the same cycle.
  - Returns to IDLE; busy and led_ld drop the next cycle.
- Latency:
  - The accepting edge is edge 0.
  - content changes on edge SETTLE+1.
  - done is visible during the cycle after edge SETTLE.
- Commands while busy (SETTLE or COMMIT): ignored; cmd_err pulses 1 cycle later; content is unaffected.
- Drive:
  - addr_oe is registered: addr_oe(next) = sel & (state==IDLE) & no write command this cycle.
  - Sel rises → oe next cycle; sel falls → oe drops next cycle.
  - addr_out = content while addr_oe, else holds its last value.
  - A write command accepted while sel=1 wins: oe deasserts next cycle and stays 0 through COMMIT.
  - Bus drive never coincides with busy=1.
- Self-load: ld_full with addr_oe=1 is legal; the captured addr_in is whatever is on the bus.
- Widths: all arithmetic is 2W bits; increment wraps silently, signalled by the carry pulse.
- Reset asserted mid-SETTLE: content stays RESET_VAL, and no done or carry pulse follows release.

Test Plan:
- Reset with W=8, SETTLE=3, RESET_VAL=16'h0000 → content=0, addr_oe=0, busy=0 immediately on rst_n low (no clock needed).
- ld_hi=1, data_in=8'hA5 for one cycle in IDLE:
  - busy=1 for 4 cycles; done pulse on cycle 4; content=16'hA500 after edge 4.
  - Then ld_lo with 8'h3C → 16'hA53C.
- content=16'hFFFF, inc=1 → after SETTLE+1 edges content=16'h0000, carry=1 coincident with done.
- ld_full with addr_in=16'h1234, then ld_lo while busy (data_in=8'hFF):
  - cmd_err pulses once; final content=16'h1234.
- sel=1 for 3 cycles → addr_oe high for exactly 3 cycles lagging by 1, addr_out=content.
  - Then assert inc while sel=1 → addr_oe drops next cycle.
- Reset pulse 2 cycles into a ld_full of 16'hBEEF → content=RESET_VAL, no done, busy=0 after release.
